mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 39 +++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Holds the FSM encoding, size codes and the latched transaction bundle.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        owner_e      owner;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    // Instruction fetches are always word reads.
    function automatic txn_t inst_txn(input logic [31:0] addr);
        txn_t t;
        t.owner = OWN_INST;
        t.wr    = 1'b0;
        t.size  = SIZE_WORD;
        t.addr  = addr;
        t.wdata = 32'd0;
        return t;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction and data sram-like ports onto one downstream bus.
// One transaction in flight; data has priority with a starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [31:0] rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_e        state_q, state_d;
    txn_t          txn_q, txn_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          starved;
    logic          grant_data;

    assign starved = (starve_q == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            txn_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            txn_q    <= txn_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        txn_d        = txn_q;
        starve_d     = starve_q;
        grant_data   = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        bus_req      = 1'b0;
        // Outputs stay quiet for the whole reset window, not just after the edge.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (inst_req || data_req) begin
                        grant_data = data_req && !(inst_req && starved);
                        if (grant_data) begin
                            data_addr_ok = 1'b1;
                            txn_d.owner  = OWN_DATA;
                            txn_d.wr     = data_wr;
                            txn_d.size   = data_size;
                            txn_d.addr   = data_addr;
                            txn_d.wdata  = data_wdata;
                            if (inst_req && !starved) begin
                                starve_d = starve_q + CW'(1);
                            end
                        end else begin
                            inst_addr_ok = 1'b1;
                            txn_d        = inst_txn(inst_addr);
                            starve_d     = '0;
                        end
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    bus_req = 1'b1;
                    if (bus_addr_ok) begin
                        state_d = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus_data_ok) begin
                        inst_data_ok = (txn_q.owner == OWN_INST);
                        data_data_ok = (txn_q.owner == OWN_DATA);
                        state_d      = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus_wr    = txn_q.wr;
    assign bus_size  = txn_q.size;
    assign bus_addr  = txn_q.addr;
    assign bus_wdata = txn_q.wdata;
    assign rdata     = bus_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Stimulus changes 1ns after rising edges; outputs checked 1ns later.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .rdata        (rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Expected grant sequence with both requesters held: 1 = inst.
    logic exp_inst [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        rst         = 1'b1;
        inst_req    = 1'b0;
        inst_addr   = 32'd0;
        data_req    = 1'b1;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_addr   = 32'd0;
        data_wdata  = 32'd0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'hA5A5_0001;

        // Reset state, with a request pending to prove gating.
        tick();
        settle();
        chk("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_rdata", rdata, 32'hA5A5_0001);
        data_req = 1'b0;
        tick();
        rst = 1'b0;

        // Single data read, minimum-ish latency.
        data_req  = 1'b1;
        data_size = 2'd2;
        data_addr = 32'h8000_0010;
        settle();
        chk("rd_data_addr_ok_c0", {31'd0, data_addr_ok}, 32'd1);
        chk("rd_inst_addr_ok_c0", {31'd0, inst_addr_ok}, 32'd0);
        chk("rd_bus_req_c0", {31'd0, bus_req}, 32'd0);
        tick();
        data_req    = 1'b0;
        bus_addr_ok = 1'b1;
        settle();
        chk("rd_bus_req_c1", {31'd0, bus_req}, 32'd1);
        chk("rd_bus_addr_c1", bus_addr, 32'h8000_0010);
        chk("rd_bus_wr_c1", {31'd0, bus_wr}, 32'd0);
        tick();
        bus_addr_ok = 1'b0;
        settle();
        chk("rd_bus_req_c2", {31'd0, bus_req}, 32'd0);
        chk("rd_data_ok_c2", {31'd0, data_data_ok}, 32'd0);
        tick();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hDEAD_BEEF;
        settle();
        chk("rd_data_ok_c3", {31'd0, data_data_ok}, 32'd1);
        chk("rd_inst_ok_c3", {31'd0, inst_data_ok}, 32'd0);
        chk("rd_rdata_c3", rdata, 32'hDEAD_BEEF);
        tick();
        bus_data_ok = 1'b0;
        settle();
        chk("rd_data_ok_c4", {31'd0, data_data_ok}, 32'd0);

        // Both requesters held: starvation guard forces every fifth grant to inst.
        inst_req   = 1'b1;
        inst_addr  = 32'h1FC0_0000;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd1;
        data_addr  = 32'h0000_2000;
        data_wdata = 32'hCAFE_0000;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk($sformatf("arb_inst_ok_%0d", i), {31'd0, inst_addr_ok},
                {31'd0, exp_inst[i]});
            chk($sformatf("arb_data_ok_%0d", i), {31'd0, data_addr_ok},
                {31'd0, !exp_inst[i]});
            tick();
            bus_addr_ok = 1'b1;
            settle();
            chk($sformatf("arb_hold_%0d", i), {31'd0, data_addr_ok}, 32'd0);
            chk($sformatf("arb_bus_wr_%0d", i), {31'd0, bus_wr},
                {31'd0, !exp_inst[i]});
            chk($sformatf("arb_bus_addr_%0d", i), bus_addr,
                exp_inst[i] ? 32'h1FC0_0000 : 32'h0000_2000);
            chk($sformatf("arb_bus_size_%0d", i), {30'd0, bus_size},
                exp_inst[i] ? 32'd2 : 32'd1);
            chk($sformatf("arb_bus_wdata_%0d", i), bus_wdata,
                exp_inst[i] ? 32'd0 : 32'hCAFE_0000);
            tick();
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b1;
            bus_rdata   = 32'h100 + i;
            settle();
            chk($sformatf("arb_inst_dok_%0d", i), {31'd0, inst_data_ok},
                {31'd0, exp_inst[i]});
            chk($sformatf("arb_data_dok_%0d", i), {31'd0, data_data_ok},
                {31'd0, !exp_inst[i]});
            tick();
            bus_data_ok = 1'b0;
        end

        // Write held in REQ while downstream stalls; fields must not move.
        inst_req   = 1'b0;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_addr  = 32'hBFAF_0000;
        data_wdata = 32'h1234_5678;
        settle();
        chk("wr_accept", {31'd0, data_addr_ok}, 32'd1);
        tick();
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = 32'h0BAD_0BAD;
        data_wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("wr_stall_req_%0d", c), {31'd0, bus_req}, 32'd1);
            chk($sformatf("wr_stall_wr_%0d", c), {31'd0, bus_wr}, 32'd1);
            chk($sformatf("wr_stall_addr_%0d", c), bus_addr, 32'hBFAF_0000);
            chk($sformatf("wr_stall_wdata_%0d", c), bus_wdata, 32'h1234_5678);
            chk($sformatf("wr_stall_size_%0d", c), {30'd0, bus_size}, 32'd2);
            tick();
        end
        bus_addr_ok = 1'b1;
        settle();
        chk("wr_bus_req_accept", {31'd0, bus_req}, 32'd1);
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        settle();
        chk("wr_done", {31'd0, data_data_ok}, 32'd1);
        tick();
        bus_data_ok = 1'b0;

        // Reset while in RESP drops the transaction.
        inst_req  = 1'b1;
        inst_addr = 32'h1FC0_0040;
        settle();
        chk("rr_accept", {31'd0, inst_addr_ok}, 32'd1);
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        rst         = 1'b1;
        settle();
        chk("rr_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rr_bus_addr", bus_addr, 32'd0);
        chk("rr_bus_size", {30'd0, bus_size}, 32'd0);
        chk("rr_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        tick();
        inst_req = 1'b0;
        rst      = 1'b0;
        bus_data_ok = 1'b1;
        settle();
        chk("rr_late_inst_dok", {31'd0, inst_data_ok}, 32'd0);
        chk("rr_late_data_dok", {31'd0, data_data_ok}, 32'd0);
        tick();

        // Spurious bus_data_ok in IDLE and REQ, inst request accepted alongside.
        inst_req  = 1'b1;
        inst_addr = 32'h1FC0_0080;
        settle();
        chk("sp_idle_dok", {31'd0, inst_data_ok}, 32'd0);
        chk("sp_idle_accept", {31'd0, inst_addr_ok}, 32'd1);
        tick();
        inst_req    = 1'b0;
        bus_addr_ok = 1'b1;
        settle();
        chk("sp_req_dok", {31'd0, inst_data_ok}, 32'd0);
        chk("sp_req_addr", bus_addr, 32'h1FC0_0080);
        tick();
        bus_addr_ok = 1'b0;
        bus_rdata   = 32'h0000_1357;
        settle();
        chk("sp_resp_dok", {31'd0, inst_data_ok}, 32'd1);
        chk("sp_resp_rdata", rdata, 32'h0000_1357);
        tick();
        bus_data_ok = 1'b0;
        settle();
        chk("sp_after_dok", {31'd0, inst_data_ok}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
